interrupt_unit: RTL and testbench
=================================

// Module: interrupt_unit
// PURPOSE
//  Parametrised successor of the single-instance interrupt/SPR block. Latches external requests until serviced,
//  masks/prioritises NUM_CAUSES causes, raises JISR, saves/restores special registers (incl. ERET), takes the
//  cause-0 reset interrupt after reset release, and halts on fatal causes. Sits beside the execute stage; PC mux consumes jisr/sisr/epc.
// PARAMETERS
//  XLEN        32          datapath / SPR width
//  NUM_CAUSES  23          cause vector width; bit 0 = reset, 0 highest priority
//  FIRST_EXT   7           causes >= FIRST_EXT are external: level-latched into pend until taken
//  NMI_MASK    'h1         causes never masked by sr; all others gated by sr[i]
//  REPEAT_MASK 'h18        causes saving epc=pc (repeat); others save epc=next_pc (continue); ext always repeat
//  ABORT_MASK  'h6         taken cause in this set -> sticky abort, enter HALT
//  SISR        32'h0       ISR entry address
// PORTS
//  clk         in  1              clock, rising edge
//  rst         in  1              asynchronous, active-low reset
//  ue          in  1              current instruction commits this cycle
//  ca          in  NUM_CAUSES     cause inputs (internal: valid with ue; external: level)
//  pc,next_pc  in  XLEN           PC of committing instr / its successor
//  ea          in  XLEN           effective address of committing instr
//  eret        in  1              ERET committing (qualified by ue)
//  spr_we      in  1              movi2s committing (qualified by ue)
//  spr_sel     in  3              0 sr,1 esr,2 eca,3 epc,4 edata,5 mode; others read 0, write ignored
//  spr_wdata   in  XLEN           movi2s data
//  spr_rdata   out XLEN           movs2i data, combinational on spr_sel
//  jisr        out 1              take interrupt this cycle
//  il          out clog2(NUM_CAUSES) index of taken cause
//  mca         out NUM_CAUSES     masked cause vector
//  sisr        out XLEN           ISR target (=SISR)
//  sr,esr,eca,epc,edata out XLEN  special registers
//  mode        out 1              1 = user, 0 = system
//  abort       out 1              sticky fatal flag
//  abort_code  out clog2(NUM_CAUSES) il of aborting cause
//  halted      out 1              FSM in HALT; pipeline must stall
// BEHAVIOUR
//  Reset (rst=0): all SPRs, pend, abort, abort_code = 0; mode=0; FSM=BOOT; outputs follow regs (jisr=0 during reset).
//  FSM BOOT: first cycle after release: jisr=1, il=0, mca=1 (independent of ue); -> RUN. eca<=1, epc<=0, esr<=0.
//  FSM RUN: eff = ca | (pend masked to ext bits); mca[i] = eff[i] & (NMI_MASK[i] | sr[i]) for i<XLEN else eff[i] & NMI_MASK[i].
//   jisr = ue & |mca; il = lowest set index of mca. Combinational same cycle, no latency.
//  pend: pend[i] <= pend[i] | ca[i] for ext i each cycle; on jisr clear only pend[il]. Internal bits never pend (dropped if masked).
//  On jisr edge: esr<=sr; eca<=zero-ext mca; edata<=ea; epc<= (REPEAT_MASK[il]|il>=FIRST_EXT)? pc : next_pc;
//   sr<=0; mode<=0; emode<=mode. If ABORT_MASK[il]: abort<=1, abort_code<=il, FSM->HALT.
//  ERET (ue&eret&!jisr): sr<=esr; mode<=emode; other SPRs unchanged. jisr has priority over eret and spr_we.
//  spr_we (ue&!jisr): write selected SPR; mode takes wdata[0]. Write to sr visible to masking next cycle.
//  Simultaneous movi2s and ERET: ERET wins for sr/mode; write to other sel still performed.
//  HALT: jisr=0, halted=1, SPRs frozen, pend keeps latching; exits only via reset.
//  mode=1 and movi2s/eret/movs2i are illegal: caller asserts the illegal-instruction cause; this block does not decode.
//  Reset mid-ISR or in HALT: immediate clear, BOOT again.
// TESTING
//  Release reset -> cycle 1 jisr=1, il=0, eca=1, mode=0; cycle 2 jisr=0, FSM RUN.
//  sr=0, ca[9] pulse 1 cycle -> no jisr; later spr_we sr=1<<9 -> jisr next ue, il=9, epc=pc, pend[9] cleared.
//  ca[5]|ca[9] with sr=all ones, pc=0x40,next_pc=0x44 -> il=5, epc=0x44, eca=0x220, pend[9] stays set; next ue il=9.
//  ca[3] with pc=0x100, ea=0x2002 -> epc=0x100 (repeat), edata=0x2002, esr=old sr; ERET -> sr=esr, mode restored.
//  ca[1] taken -> abort=1, abort_code=1, halted=1; further ca ignored; rst low -> abort=0, BOOT.
//  ue&eret&ca[6] same cycle -> jisr=1, sr<=0 (eret discarded).

Source files
------------

// File: rtl/interrupt_unit.sv
// interrupt_unit: latches/masks/prioritises causes, raises JISR, saves and restores SPRs,
// takes the cause-0 boot interrupt after reset release and halts on fatal causes.
module interrupt_unit #(
   parameter int                     XLEN        = 32,
   parameter int                     NUM_CAUSES  = 23,
   parameter int                     FIRST_EXT   = 7,
   parameter logic [NUM_CAUSES-1:0]  NMI_MASK    = 'h1,
   parameter logic [NUM_CAUSES-1:0]  REPEAT_MASK = 'h18,
   parameter logic [NUM_CAUSES-1:0]  ABORT_MASK  = 'h6,
   parameter logic [XLEN-1:0]        SISR        = '0
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          ue_i,
   input  logic [NUM_CAUSES-1:0]         ca_i,
   input  logic [XLEN-1:0]               pc_i,
   input  logic [XLEN-1:0]               next_pc_i,
   input  logic [XLEN-1:0]               ea_i,
   input  logic                          eret_i,
   input  logic                          spr_we_i,
   input  logic [2:0]                    spr_sel_i,
   input  logic [XLEN-1:0]               spr_wdata_i,
   output logic [XLEN-1:0]               spr_rdata_o,
   output logic                          jisr_o,
   output logic [$clog2(NUM_CAUSES)-1:0] il_o,
   output logic [NUM_CAUSES-1:0]         mca_o,
   output logic [XLEN-1:0]               sisr_o,
   output logic [XLEN-1:0]               sr_o,
   output logic [XLEN-1:0]               esr_o,
   output logic [XLEN-1:0]               eca_o,
   output logic [XLEN-1:0]               epc_o,
   output logic [XLEN-1:0]               edata_o,
   output logic                          mode_o,
   output logic                          abort_o,
   output logic [$clog2(NUM_CAUSES)-1:0] abort_code_o,
   output logic                          halted_o
);
   localparam int IW = $clog2(NUM_CAUSES);
   localparam logic [NUM_CAUSES-1:0] EXT_MASK = {NUM_CAUSES{1'b1}} << FIRST_EXT;
   // External causes always resume at the interrupted instruction.
   localparam logic [NUM_CAUSES-1:0] REP_MASK = REPEAT_MASK | EXT_MASK;

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;

   state_e                state_q, state_d;
   logic [XLEN-1:0]       sr_q, sr_d, esr_q, esr_d, eca_q, eca_d;
   logic [XLEN-1:0]       epc_q, epc_d, edata_q, edata_d;
   logic                  mode_q, mode_d, emode_q, emode_d, abort_q, abort_d;
   logic [IW-1:0]         abort_code_q, abort_code_d, il;
   logic [NUM_CAUSES-1:0] pend_q, pend_d, eff, mca;
   logic                  jisr;

   assign eff = ca_i | (pend_q & EXT_MASK);

   // BOOT presents cause 0 unconditionally, but never while reset is held.
   always_comb begin
      mca  = '0;
      jisr = 1'b0;
      if (state_q == BOOT) begin
         mca  = NUM_CAUSES'(rst_ni);
         jisr = rst_ni;
      end else if (state_q == RUN) begin
         mca  = eff & (NMI_MASK | NUM_CAUSES'(sr_q));
         jisr = ue_i & (|mca);
      end
   end

   always_comb begin
      il = '0;
      for (int i = NUM_CAUSES - 1; i >= 0; i--)
         if (mca[i]) il = IW'(i);
   end

   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      esr_d        = esr_q;
      eca_d        = eca_q;
      epc_d        = epc_q;
      edata_d      = edata_q;
      mode_d       = mode_q;
      emode_d      = emode_q;
      abort_d      = abort_q;
      abort_code_d = abort_code_q;
      pend_d       = pend_q | (ca_i & EXT_MASK);
      if (state_q == BOOT) begin
         state_d = RUN;
         eca_d   = XLEN'(1);
         epc_d   = '0;
         esr_d   = '0;
      end else if (state_q == RUN && jisr) begin
         esr_d      = sr_q;
         eca_d      = XLEN'(mca);
         edata_d    = ea_i;
         epc_d      = REP_MASK[il] ? pc_i : next_pc_i;
         sr_d       = '0;
         mode_d     = 1'b0;
         emode_d    = mode_q;
         pend_d[il] = 1'b0;
         if (ABORT_MASK[il]) begin
            abort_d      = 1'b1;
            abort_code_d = il;
            state_d      = HALT;
         end
      end else if (state_q == RUN && ue_i) begin
         if (spr_we_i) begin
            sr_d    = spr_sel_i == 3'd0 ? spr_wdata_i : sr_q;
            esr_d   = spr_sel_i == 3'd1 ? spr_wdata_i : esr_q;
            eca_d   = spr_sel_i == 3'd2 ? spr_wdata_i : eca_q;
            epc_d   = spr_sel_i == 3'd3 ? spr_wdata_i : epc_q;
            edata_d = spr_sel_i == 3'd4 ? spr_wdata_i : edata_q;
            mode_d  = spr_sel_i == 3'd5 ? spr_wdata_i[0] : mode_q;
         end
         // ERET overrides a same-cycle movi2s to sr/mode.
         if (eret_i) begin
            sr_d   = esr_q;
            mode_d = emode_q;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= BOOT;
         sr_q         <= '0;
         esr_q        <= '0;
         eca_q        <= '0;
         epc_q        <= '0;
         edata_q      <= '0;
         mode_q       <= 1'b0;
         emode_q      <= 1'b0;
         abort_q      <= 1'b0;
         abort_code_q <= '0;
         pend_q       <= '0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         esr_q        <= esr_d;
         eca_q        <= eca_d;
         epc_q        <= epc_d;
         edata_q      <= edata_d;
         mode_q       <= mode_d;
         emode_q      <= emode_d;
         abort_q      <= abort_d;
         abort_code_q <= abort_code_d;
         pend_q       <= pend_d;
      end
   end

   assign spr_rdata_o  = spr_sel_i == 3'd0 ? sr_q    :
                         spr_sel_i == 3'd1 ? esr_q   :
                         spr_sel_i == 3'd2 ? eca_q   :
                         spr_sel_i == 3'd3 ? epc_q   :
                         spr_sel_i == 3'd4 ? edata_q :
                         spr_sel_i == 3'd5 ? XLEN'(mode_q) : '0;
   assign jisr_o       = jisr;
   assign il_o         = il;
   assign mca_o        = mca;
   assign sisr_o       = SISR;
   assign sr_o         = sr_q;
   assign esr_o        = esr_q;
   assign eca_o        = eca_q;
   assign epc_o        = epc_q;
   assign edata_o      = edata_q;
   assign mode_o       = mode_q;
   assign abort_o      = abort_q;
   assign abort_code_o = abort_code_q;
   assign halted_o     = state_q == HALT;
endmodule

// File: tb/tb_interrupt_unit.sv
// tb_interrupt_unit: directed scenarios plus random traffic against a cause-level reference model.
module tb_interrupt_unit;
   logic        clk = 1'b0, rst_ni = 1'b0, ue_i = 1'b0, eret_i = 1'b0, spr_we_i = 1'b0;
   logic [22:0] ca_i = '0;
   logic [31:0] pc_i = '0, next_pc_i = '0, ea_i = '0, spr_wdata_i = '0;
   logic [2:0]  spr_sel_i = '0;
   logic [31:0] spr_rdata_o, sisr_o, sr_o, esr_o, eca_o, epc_o, edata_o;
   logic        jisr_o, mode_o, abort_o, halted_o;
   logic [4:0]  il_o, abort_code_o;
   logic [22:0] mca_o;

   interrupt_unit dut (
      .clk_i(clk), .rst_ni(rst_ni), .ue_i(ue_i), .ca_i(ca_i), .pc_i(pc_i), .next_pc_i(next_pc_i),
      .ea_i(ea_i), .eret_i(eret_i), .spr_we_i(spr_we_i), .spr_sel_i(spr_sel_i),
      .spr_wdata_i(spr_wdata_i), .spr_rdata_o(spr_rdata_o), .jisr_o(jisr_o), .il_o(il_o),
      .mca_o(mca_o), .sisr_o(sisr_o), .sr_o(sr_o), .esr_o(esr_o), .eca_o(eca_o), .epc_o(epc_o),
      .edata_o(edata_o), .mode_o(mode_o), .abort_o(abort_o), .abort_code_o(abort_code_o),
      .halted_o(halted_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   bit m_boot, m_halt, m_mode, m_emode, m_abort;
   int m_code;
   logic [31:0] m_sr, m_esr, m_eca, m_epc, m_edata;
   bit m_pend [23];
   bit l_jisr;
   int l_il;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_boot = 1; m_halt = 0; m_mode = 0; m_emode = 0; m_abort = 0; m_code = 0;
      m_sr = 0; m_esr = 0; m_eca = 0; m_epc = 0; m_edata = 0;
      foreach (m_pend[i]) m_pend[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      check("rst_jisr", 32'(jisr_o), 0);
      check("rst_sr", sr_o, 0);
      check("rst_eca", eca_o, 0);
      check("rst_epc", epc_o, 0);
      check("rst_mode", 32'(mode_o), 0);
      check("rst_abort", 32'(abort_o), 0);
      check("rst_code", 32'(abort_code_o), 0);
      check("rst_halted", 32'(halted_o), 0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
   endtask

   task automatic step(input bit ue, input logic [22:0] ca, input logic [31:0] pc, npc, ea,
                       input bit eret, we, input logic [2:0] sel, input logic [31:0] wd);
      logic [22:0] e_mca;
      logic [31:0] e_rd;
      bit e_jisr, found;
      int e_il;
      logic [31:0] o_esr;
      bit o_emode;
      ue_i = ue; ca_i = ca; pc_i = pc; next_pc_i = npc; ea_i = ea;
      eret_i = eret; spr_we_i = we; spr_sel_i = sel; spr_wdata_i = wd;
      #1;
      e_mca = '0;
      if (m_boot) e_mca = 23'd1;
      else if (!m_halt)
         for (int i = 0; i < 23; i++)
            if ((ca[i] || (i >= 7 && m_pend[i])) && (i == 0 || m_sr[i])) e_mca[i] = 1'b1;
      e_jisr = m_boot || (!m_halt && ue && e_mca != 0);
      found = 0; e_il = 0;
      for (int i = 0; i < 23; i++)
         if (e_mca[i] && !found) begin e_il = i; found = 1; end
      case (sel)
         3'd0: e_rd = m_sr;
         3'd1: e_rd = m_esr;
         3'd2: e_rd = m_eca;
         3'd3: e_rd = m_epc;
         3'd4: e_rd = m_edata;
         3'd5: e_rd = 32'(m_mode);
         default: e_rd = 0;
      endcase
      check("jisr", 32'(jisr_o), 32'(e_jisr));
      check("mca", 32'(mca_o), 32'(e_mca));
      if (found) check("il", 32'(il_o), e_il);
      check("rdata", spr_rdata_o, e_rd);
      check("sr", sr_o, m_sr);
      check("esr", esr_o, m_esr);
      check("eca", eca_o, m_eca);
      check("epc", epc_o, m_epc);
      check("edata", edata_o, m_edata);
      check("mode", 32'(mode_o), 32'(m_mode));
      check("abort", 32'(abort_o), 32'(m_abort));
      check("code", 32'(abort_code_o), m_code);
      check("halted", 32'(halted_o), 32'(m_halt));
      check("sisr", sisr_o, 0);
      l_jisr = jisr_o; l_il = int'(il_o);
      @(posedge clk);
      for (int i = 7; i < 23; i++) if (ca[i]) m_pend[i] = 1;
      if (m_boot) begin
         m_boot = 0; m_eca = 1; m_epc = 0; m_esr = 0;
      end else if (!m_halt && e_jisr) begin
         m_esr = m_sr; m_eca = 32'(e_mca); m_edata = ea;
         m_epc = (e_il == 3 || e_il == 4 || e_il >= 7) ? pc : npc;
         m_sr = 0; m_emode = m_mode; m_mode = 0; m_pend[e_il] = 0;
         if (e_il == 1 || e_il == 2) begin m_abort = 1; m_code = e_il; m_halt = 1; end
      end else if (!m_halt && ue) begin
         o_esr = m_esr; o_emode = m_emode;
         if (we)
            case (sel)
               3'd0: m_sr = wd;
               3'd1: m_esr = wd;
               3'd2: m_eca = wd;
               3'd3: m_epc = wd;
               3'd4: m_edata = wd;
               3'd5: m_mode = wd[0];
               default: ;
            endcase
         if (eret) begin m_sr = o_esr; m_mode = o_emode; end
      end
      @(negedge clk);
   endtask

   task automatic rand_step(input bit allow_abort);
      logic [22:0] ca = '0;
      for (int i = 0; i < 23; i++)
         if ((allow_abort || (i != 1 && i != 2)) && $urandom_range(15) == 0) ca[i] = 1'b1;
      step($urandom_range(3) != 0, ca, $urandom, $urandom, $urandom,
           $urandom_range(7) == 0, $urandom_range(3) == 0, 3'($urandom_range(7)), $urandom);
   endtask

   initial begin
      model_reset();
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("boot_jisr", 32'(l_jisr), 1);
      check("boot_il", l_il, 0);
      check("boot_eca", eca_o, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("run_jisr", 32'(l_jisr), 0);
      // masked external pulse stays pending until sr enables it
      step(1, 23'(1 << 9), 0, 0, 0, 0, 0, 0, 0);
      check("masked_jisr", 32'(l_jisr), 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 32'h200);
      step(1, 0, 32'h80, 32'h84, 0, 0, 0, 0, 0);
      check("pend_il9", l_il, 9);
      check("pend_epc", epc_o, 32'h80);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("pend_cleared", 32'(l_jisr), 0);
      // priority and continue-type epc
      step(1, 0, 0, 0, 0, 0, 1, 0, 32'hffffffff);
      step(1, 23'h220, 32'h40, 32'h44, 0, 0, 0, 0, 0);
      check("prio_il5", l_il, 5);
      check("prio_eca", eca_o, 32'h220);
      check("prio_epc", epc_o, 32'h44);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("next_il9", l_il, 9);
      // repeat-type cause and ERET restore
      step(1, 0, 0, 0, 0, 0, 1, 0, 32'hffffffff);
      step(1, 0, 0, 0, 0, 0, 1, 5, 1);
      step(1, 23'(1 << 3), 32'h100, 32'h104, 32'h2002, 0, 0, 0, 0);
      check("rep_epc", epc_o, 32'h100);
      check("rep_edata", edata_o, 32'h2002);
      check("rep_esr", esr_o, 32'hffffffff);
      check("rep_mode", 32'(mode_o), 0);
      step(1, 0, 0, 0, 0, 1, 0, 0, 0);
      check("eret_sr", sr_o, 32'hffffffff);
      check("eret_mode", 32'(mode_o), 1);
      // jisr beats eret
      step(1, 23'(1 << 6), 32'h10, 32'h14, 0, 1, 0, 0, 0);
      check("prio_eret_jisr", 32'(l_jisr), 1);
      check("prio_eret_sr", sr_o, 0);
      for (int n = 0; n < 1500; n++) rand_step(0);
      // fatal cause halts until reset
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 1, 0, 32'hffffffff);
      step(1, 23'(1 << 1), 0, 0, 0, 0, 0, 0, 0);
      check("abort", 32'(abort_o), 1);
      check("abort_code", 32'(abort_code_o), 1);
      check("halted", 32'(halted_o), 1);
      for (int n = 0; n < 40; n++) rand_step(1);
      do_reset();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("reboot_jisr", 32'(l_jisr), 1);
      for (int n = 0; n < 300; n++) rand_step(1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
